// File: rtl/deser_queue_param.sv
// deser_queue_param: serial-to-parallel receiver feeding a DEPTH-entry
// circular word queue. Bits arrive on rising edges of write_in, words are
// popped on rising edges of dequeue_in. A completed word that finds the
// queue full is held (status_out low) until a pop frees a slot.
module deser_queue_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  output logic             status_out,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic [LW-1:0]    len_out,
  output logic             overflow_out
);

  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

  typedef enum logic {RECV = 1'b0, PUSH = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             write_q, deq_q;
  logic             status_q, status_d;
  logic             overflow_q, overflow_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_stb, deq_stb, capture, last_bit, full, push, pop;

  // Strobe decode and queue-side qualifiers shared by both comb processes.
  always_comb begin
    wr_stb   = write_in & ~write_q;
    deq_stb  = dequeue_in & ~deq_q;
    // status_q is only high in RECV, so it alone gates bit capture; this
    // also rejects a strobe landing on the first edge after reset.
    capture  = wr_stb & status_q;
    last_bit = capture && (bit_cnt_q == LAST_BIT);
    full     = (len_q == FULL_LEN);
    // A full queue still accepts the held word when a pop frees a slot
    // in the same cycle.
    push     = (state_q == PUSH) && (!full || deq_stb);
    pop      = deq_stb && (len_q != '0);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= RECV;
    else       state_q <= state_d;
  end

  // FSM next state: leave RECV on the last bit, leave PUSH once written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV:    if (last_bit) state_d = PUSH;
      PUSH:    if (push)     state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // FSM outputs and datapath next-state values.
  always_comb begin
    status_d   = (state_d == RECV);
    overflow_d = overflow_q | (wr_stb & ~status_q);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;

    if (capture) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
      // Shifting in from the far end places the i-th received bit at
      // word[i] (LSB first) or word[WIDTH-1-i] (MSB first) after WIDTH bits.
      if (LSB_FIRST) shift_d = {data_in, shift_q[WIDTH-1:1]};
      else           shift_d = {shift_q[WIDTH-2:0], data_in};
    end

    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_q    <= 1'b0;
      deq_q      <= 1'b0;
      status_q   <= 1'b0;
      overflow_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
    end else begin
      write_q    <= write_in;
      deq_q      <= dequeue_in;
      status_q   <= status_d;
      overflow_q <= overflow_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
    end
  end

  // Queue storage; contents need no reset because len gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= shift_q;
  end

  // Head word is read asynchronously so a word is visible in the same
  // cycle len_out reports it.
  assign data_out     = (len_q != '0) ? mem[rd_ptr_q] : '0;
  assign len_out      = len_q;
  assign status_out   = status_q;
  assign overflow_out = overflow_q;

endmodule
